// File: rtl/mem_arb_pkg.sv
// Shared constants and the round-robin pick helper for the memory port arbiter.
package mem_arb_pkg;

   localparam int REQ_W_DEFAULT = 100;
   localparam int RSP_W_DEFAULT = 65;

   // Owner encoding stored in the owner FIFO
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   typedef struct packed {
      logic grant_if;
      logic grant_ls;
   } grant_t;

   // Single requester wins outright; on a tie the side not granted last wins.
   function automatic grant_t rr_pick(input logic if_valid,
                                      input logic ls_valid,
                                      input logic last_grant);
      grant_t g;
      g.grant_if = 1'b0;
      g.grant_ls = 1'b0;
      case ({if_valid, ls_valid})
         2'b10: g.grant_if = 1'b1;
         2'b01: g.grant_ls = 1'b1;
         2'b11: begin
            if (last_grant == OWNER_IF) begin
               g.grant_ls = 1'b1;
            end else begin
               g.grant_if = 1'b1;
            end
         end
         default: begin
            g.grant_if = 1'b0;
            g.grant_ls = 1'b0;
         end
      endcase
      return g;
   endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order 1-bit owner FIFO: records which requester owns each outstanding request.
module arb_owner_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_data,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_en_s;
   logic             pop_en_s;

   assign push_en_s = push && !full;
   assign pop_en_s  = pop && !empty;

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == {(AW+1){1'b0}});

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_en_s, pop_en_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Owner storage; contents are don't-care while the slot is not occupied
   always_ff @(posedge clk) begin
      if (push_en_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-to-one arbiter sharing the memory request port between fetch and load/store,
// with in-order routing of memory responses back to the issuing requester.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int REQ_W           = REQ_W_DEFAULT,
   parameter int RSP_W           = RSP_W_DEFAULT,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req_valid,
   input  logic [REQ_W-1:0] if_req_bus,
   output logic             arb_if_allow_in,
   input  logic             ls_req_valid,
   input  logic [REQ_W-1:0] ls_req_bus,
   output logic             arb_ls_allow_in,
   output logic             arb_to_mem_valid,
   output logic [REQ_W-1:0] arb_to_mem_bus,
   input  logic             mem_allow_in,
   input  logic             mem_to_arb_valid,
   input  logic [RSP_W-1:0] mem_to_arb_bus,
   output logic             arb_rsp_allow_in,
   output logic             arb_to_if_valid,
   output logic [RSP_W-1:0] arb_to_if_bus,
   input  logic             if_rsp_allow_in,
   output logic             arb_to_ls_valid,
   output logic [RSP_W-1:0] arb_to_ls_bus,
   input  logic             ls_rsp_allow_in
);

   logic             req_valid_r;
   logic [REQ_W-1:0] req_reg_r;
   logic             last_grant_r;
   logic             req_allow_in_s;
   logic             can_grant_s;
   logic             grant_fire_s;
   logic             grant_owner_s;
   grant_t           pick_s;
   logic             fifo_head_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             fifo_pop_s;

   // A full owner FIFO blocks granting even if a response pops this cycle
   assign req_allow_in_s = !req_valid_r || mem_allow_in;
   assign can_grant_s    = req_allow_in_s && !fifo_full_s;
   assign pick_s         = rr_pick(if_req_valid, ls_req_valid, last_grant_r);

   assign arb_if_allow_in = can_grant_s && pick_s.grant_if;
   assign arb_ls_allow_in = can_grant_s && pick_s.grant_ls;
   assign grant_fire_s    = arb_if_allow_in || arb_ls_allow_in;
   assign grant_owner_s   = pick_s.grant_ls ? OWNER_LS : OWNER_IF;

   assign arb_to_mem_valid = req_valid_r;
   assign arb_to_mem_bus   = req_reg_r;

   // Request stage valid and round-robin history; history moves only on a real grant
   always_ff @(posedge clk) begin
      if (reset) begin
         req_valid_r  <= 1'b0;
         last_grant_r <= OWNER_IF;
      end else if (grant_fire_s) begin
         req_valid_r  <= 1'b1;
         last_grant_r <= grant_owner_s;
      end else if (req_allow_in_s) begin
         req_valid_r  <= 1'b0;
      end else begin
         req_valid_r  <= req_valid_r;
      end
   end

   // Request payload; held while memory stalls, so no reset is needed
   always_ff @(posedge clk) begin
      if (grant_fire_s) begin
         req_reg_r <= pick_s.grant_ls ? ls_req_bus : if_req_bus;
      end
   end

   // Responses pass straight through to whichever requester owns the FIFO head
   assign arb_to_if_valid  = mem_to_arb_valid && !fifo_empty_s && (fifo_head_s == OWNER_IF);
   assign arb_to_ls_valid  = mem_to_arb_valid && !fifo_empty_s && (fifo_head_s == OWNER_LS);
   assign arb_to_if_bus    = mem_to_arb_bus;
   assign arb_to_ls_bus    = mem_to_arb_bus;
   assign arb_rsp_allow_in = !fifo_empty_s &&
                             ((fifo_head_s == OWNER_LS) ? ls_rsp_allow_in : if_rsp_allow_in);
   assign fifo_pop_s       = mem_to_arb_valid && arb_rsp_allow_in;

   arb_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (grant_fire_s),
      .push_data (grant_owner_s),
      .pop       (fifo_pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-to-one ready-valid arbiter that lets the instruction-fetch stage and the load/store stage share the single memory request port. It registers one granted request toward memory and keeps an in-order owner FIFO so that each memory response is routed back to the requester that issued it. Every channel uses the valid/allow_in handshake that all pipeline stages in the rv64 core use.

## Interface
Parameters:
- REQ_W, default 100: request bus width (addr + wdata + wstrb + cmd).
- RSP_W, default 65: response bus width (rdata + err).
- MAX_OUTSTANDING, default 4: maximum number of granted requests awaiting a response. Must be a power of two, at least 2.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- if_req_valid, in, 1: fetch request valid.
- if_req_bus, in, REQ_W: fetch request payload.
- arb_if_allow_in, out, 1: fetch request accepted this cycle when high together with if_req_valid.
- ls_req_valid, in, 1: load/store request valid.
- ls_req_bus, in, REQ_W: load/store request payload.
- arb_ls_allow_in, out, 1: load/store request accepted this cycle when high together with ls_req_valid.
- arb_to_mem_valid, out, 1: registered request valid toward memory.
- arb_to_mem_bus, out, REQ_W: registered request payload toward memory.
- mem_allow_in, in, 1: memory accepts the request this cycle.
- mem_to_arb_valid, in, 1: memory response valid.
- mem_to_arb_bus, in, RSP_W: memory response payload.
- arb_rsp_allow_in, out, 1: arbiter accepts the memory response this cycle.
- arb_to_if_valid, out, 1: response valid toward fetch.
- arb_to_if_bus, out, RSP_W: response payload toward fetch.
- if_rsp_allow_in, in, 1: fetch accepts the response.
- arb_to_ls_valid, out, 1: response valid toward load/store.
- arb_to_ls_bus, out, RSP_W: response payload toward load/store.
- ls_rsp_allow_in, in, 1: load/store accepts the response.

## Operation
Request register:
- req_valid and req_reg form a standard stage register.
- req_allow_in = !req_valid || mem_allow_in.
- arb_to_mem_valid = req_valid; arb_to_mem_bus = req_reg.

Grant:
- can_grant = req_allow_in && (owner count < MAX_OUTSTANDING).
- Only one requester present: that requester wins.
- Both present: round-robin. The requester that was not granted last wins.
- last_grant updates only on an actual grant.
- arb_if_allow_in = can_grant && grant_if; arb_ls_allow_in = can_grant && grant_ls. These depend combinationally on the valids.
- On a grant: req_reg <= winner's bus, req_valid <= 1, and the owner bit (0 = IF, 1 = LS) is pushed into the owner FIFO.
- When req_allow_in is high and there is no grant: req_valid <= 0.

Response routing:
- The response path is combinational. owner = owner FIFO head.
- arb_to_if_valid = mem_to_arb_valid && !empty && owner == 0.
- arb_to_ls_valid = mem_to_arb_valid && !empty && owner == 1.
- Both response buses carry mem_to_arb_bus unmodified.
- arb_rsp_allow_in = !empty && (owner ? ls_rsp_allow_in : if_rsp_allow_in).
- The FIFO is popped when mem_to_arb_valid && arb_rsp_allow_in.

Boundary rules:
- FIFO full: no grant, even if a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged.
- Response arrives while the FIFO is empty: arb_rsp_allow_in = 0, so the response stalls and is never dropped.
- Pointers wrap modulo MAX_OUTSTANDING. The count is $clog2(MAX_OUTSTANDING)+1 bits wide.

## Timing
- Reset values:
  - req_valid = 0, so arb_to_mem_valid = 0.
  - FIFO empty, count = 0.
  - last_grant = IF, so LS wins the first tie.
  - All response valids and arb_rsp_allow_in = 0.
  - req_reg is not reset.
- Request latency: a request accepted in cycle N appears on arb_to_mem_valid in cycle N+1.
- Back-to-back throughput is one request per cycle while mem_allow_in stays high and the FIFO is not full.
- Response latency: 0 cycles, combinational pass-through.
- Reset asserted mid-operation: the next cycle has an empty FIFO and req_valid = 0. Outstanding responses are the system's responsibility, because the memory is reset together with the arbiter.
- Stable-hold rule: while arb_to_mem_valid && !mem_allow_in, arb_to_mem_bus holds stable.

## Structure
- Package mem_arb_pkg holds:
  - the REQ_W and RSP_W defaults;
  - the owner encoding constants OWNER_IF = 1'b0 and OWNER_LS = 1'b1.
- Sub-module arb_owner_fifo: 1-bit-wide synchronous FIFO with depth MAX_OUTSTANDING, push/pop inputs, head/full/empty outputs, and synchronous active-high reset.

## Test plan
- Reset, then IF-only request with addr 0x1000 and mem_allow_in = 1:
  - arb_if_allow_in = 1 in cycle 0;
  - arb_to_mem_valid = 1 with the same bus in cycle 1;
  - a response in cycle 3 appears on arb_to_if_valid only.
- IF and LS both valid every cycle for 4 cycles with mem_allow_in = 1:
  - grants go LS, IF, LS, IF;
  - the owner FIFO becomes full, so there is no grant in cycle 4.
- mem_allow_in = 0 for 3 cycles with a request pending:
  - arb_to_mem_bus is stable;
  - both arb_*_allow_in = 0;
  - the request issues in the cycle mem_allow_in returns.
- Responses for owners {IF, LS} with ls_rsp_allow_in = 0:
  - the IF response pops;
  - the LS response stalls (arb_rsp_allow_in = 0) until ls_rsp_allow_in = 1.
- Spurious mem_to_arb_valid while the FIFO is empty: arb_rsp_allow_in = 0 and no routed valid.
- Reset asserted with 2 outstanding requests and req_valid = 1: the next cycle has count = 0, arb_to_mem_valid = 0, and LS wins the next tie.
